// File: rtl/tilelink_arbiter.sv
// Two-requester round-robin arbiter in front of one TileLink-UL slave, one transaction in flight.
// Optional slave-response timeout is built only when TILELINK_ARBITER_TIMEOUT_EN is defined.

package tilelink_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned SINK_W = 2;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] PUT_FULL_DATA   = 3'd0;
  localparam logic [OP_W-1:0] GET             = 3'd4;
  localparam logic [OP_W-1:0] ACCESS_ACK      = 3'd0;
  localparam logic [OP_W-1:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic              a_valid;
    logic [OP_W-1:0]   a_opcode;
    logic [2:0]        a_param;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [MASK_W-1:0] a_mask;
    logic [DATA_W-1:0] a_data;
  } tilelink_a;

  // d_ready travels with the D payload and doubles as the A-channel accept.
  typedef struct packed {
    logic              d_valid;
    logic              d_ready;
    logic [OP_W-1:0]   d_opcode;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic [SINK_W-1:0] d_sink;
    logic [DATA_W-1:0] d_data;
    logic              d_error;
  } tilelink_d;
endpackage

module tilelink_arbiter
  import tilelink_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a m0_tla,
  output tilelink_d m0_tld,
  input  tilelink_a m1_tla,
  output tilelink_d m1_tld,
  output tilelink_a s_tla,
  input  tilelink_d s_tld,
  output logic      busy,
  output logic      grant_id
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t    state_q, state_d;
  logic      grant_q, grant_d;
  logic      favour_q, favour_d;
  logic      req0, req1;
  logic      pick, fire;
  tilelink_d rsp;
  logic      timeout_c;

  // Requests are masked during reset so nothing reaches the slave.
  assign req0 = m0_tla.a_valid & reset_n;
  assign req1 = m1_tla.a_valid & reset_n;

`ifdef TILELINK_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             unused_d_ready;

  assign unused_d_ready = s_tld.d_ready;
  assign timeout_c = (state_q == WAIT) && !s_tld.d_valid
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it starts from zero on every entry to WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              cnt_q <= '0;
    else if (state_q == IDLE)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  logic [32:0] unused_cfg;

  assign unused_cfg = {s_tld.d_ready, 32'(TIMEOUT_CYCLES)};
  assign timeout_c  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      favour_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      favour_q <= favour_d;
    end
  end

  // Grant, routing and next-state decode.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    favour_d = favour_q;
    s_tla    = '0;
    m0_tld   = '0;
    m1_tld   = '0;
    pick     = favour_q;
    fire     = 1'b0;
    rsp      = s_tld;
    rsp.d_ready = 1'b0;
    if (timeout_c) begin
      rsp          = '0;
      rsp.d_valid  = 1'b1;
      rsp.d_error  = 1'b1;
      rsp.d_opcode = ACCESS_ACK_DATA;
    end

    case (state_q)
      IDLE: begin
        m0_tld.d_ready = 1'b1;
        m1_tld.d_ready = 1'b1;
        if (req0 || req1) begin
          pick           = (req0 && req1) ? favour_q : req1;
          s_tla          = pick ? m1_tla : m0_tla;
          m0_tld.d_ready = !pick;
          m1_tld.d_ready = pick;
          grant_d        = pick;
          favour_d       = !pick;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        fire = s_tld.d_valid || timeout_c;
        if (fire) begin
          if (grant_q) m1_tld = rsp;
          else         m0_tld = rsp;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy     = (state_q == WAIT);
  assign grant_id = grant_q;

endmodule
